// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one a/b bit per accepted beat, registered sum/carry
// one cycle later, with out_last flagging the word's final bit and carry-out.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic out_valid,
  output logic sum,
  output logic carry,
  output logic out_last
);

  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_next_s;
  logic            carry_r;
  logic            carry_next_s;
  logic            carry_in_s;
  logic            sum_bit_s;
  logic            maj_s;
  logic            last_beat_s;
  logic            out_valid_next_s;
  logic            sum_next_s;
  logic            carry_next_out_s;
  logic            out_last_next_s;

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // The word's first beat takes cin; later beats chain the stored carry.
  assign carry_in_s  = (state_r == RUN) ? carry_r : cin;
  assign sum_bit_s   = a ^ b ^ carry_in_s;
  assign maj_s       = majority(a, b, carry_in_s);
  // In IDLE the count is zero, so this is only true there when WIDTH is 1.
  assign last_beat_s = (cnt_r == CW'(WIDTH - 1));

  // State, counter, stored carry and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      carry_r   <= 1'b0;
      out_valid <= 1'b0;
      sum       <= 1'b0;
      carry     <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      carry_r   <= carry_next_s;
      out_valid <= out_valid_next_s;
      sum       <= sum_next_s;
      carry     <= carry_next_out_s;
      out_last  <= out_last_next_s;
    end
  end

  // Next state: stalls hold everything; the final bit returns to IDLE.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    carry_next_s = carry_r;
    if (in_valid) begin
      carry_next_s = maj_s;
      case (state_r)
        IDLE: begin
          if (last_beat_s) begin
            state_next_s = IDLE;
            cnt_next_s   = {CW{1'b0}};
          end else begin
            state_next_s = RUN;
            cnt_next_s   = CW'(1);
          end
        end
        RUN: begin
          if (last_beat_s) begin
            state_next_s = IDLE;
            cnt_next_s   = {CW{1'b0}};
          end else begin
            state_next_s = RUN;
            cnt_next_s   = cnt_r + CW'(1);
          end
        end
        default: begin
          state_next_s = IDLE;
          cnt_next_s   = {CW{1'b0}};
        end
      endcase
    end else begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      carry_next_s = carry_r;
    end
  end

  // Output values are gated so idle cycles present all zeros.
  always_comb begin
    out_valid_next_s = in_valid;
    sum_next_s       = in_valid & sum_bit_s;
    carry_next_out_s = in_valid & maj_s;
    out_last_next_s  = in_valid & last_beat_s;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances driven
// beat by beat, with expected beats queued at drive time and popped at output.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic in_valid, a, b, cin;
  logic out_valid, sum, carry, out_last;
  logic in_valid1, a1, b1, cin1;
  logic out_valid1, sum1, carry1, out_last1;

  typedef struct packed {
    logic sum;
    logic carry;
    logic last;
  } exp_t;

  exp_t q[$];
  int tests_run = 0;
  int failed = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .sum(sum), .carry(carry), .out_last(out_last)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(out_valid1), .sum(sum1), .carry(carry1), .out_last(out_last1)
  );

  // Drive nbeats of a word (optionally stalling before beat stall_at) and check each output beat.
  task automatic send_word(input logic [7:0] wa, input logic [7:0] wb, input logic wcin,
                           input int nbeats, input int stall_at, input int stall_len,
                           input string name, output logic [7:0] sum_word, output logic cout);
    exp_t e;
    int   tot;
    int   m;
    sum_word = 8'h00;
    cout     = 1'b0;
    tot      = int'(wa) + int'(wb) + int'(wcin);
    for (int i = 0; i < nbeats; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          in_valid = 1'b0;
          a   = 1'($urandom_range(1, 0));
          b   = 1'($urandom_range(1, 0));
          cin = 1'($urandom_range(1, 0));
          @(negedge clk);
          tests_run++;
          if ({out_valid, sum, carry, out_last} !== 4'b0000) begin
            failed++;
            $display("FAIL %s stall cycle %0d: got v/s/c/l=%b%b%b%b, expected 0000",
                     name, s, out_valid, sum, carry, out_last);
          end
        end
      end
      in_valid = 1'b1;
      a   = wa[i];
      b   = wb[i];
      cin = (i == 0) ? wcin : 1'($urandom_range(1, 0));
      m = (1 << (i + 1)) - 1;
      e.sum   = 1'((tot >> i) & 1);
      e.carry = 1'((((int'(wa) & m) + (int'(wb) & m) + int'(wcin)) >> (i + 1)) & 1);
      e.last  = (i == 7);
      q.push_back(e);
      @(negedge clk);
      tests_run++;
      if (q.size() == 0) begin
        failed++;
        $display("FAIL %s beat %0d: scoreboard empty", name, i);
      end else begin
        e = q.pop_front();
        if (out_valid !== 1'b1 || sum !== e.sum || carry !== e.carry || out_last !== e.last) begin
          failed++;
          $display("FAIL %s beat %0d: got v/s/c/l=%b%b%b%b, expected 1%b%b%b",
                   name, i, out_valid, sum, carry, out_last, e.sum, e.carry, e.last);
        end
      end
      sum_word[i] = sum;
      cout        = carry;
    end
  endtask

  // Hold in_valid low with noisy data for n cycles; outputs must stay all zero.
  task automatic idle(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      a   = 1'($urandom_range(1, 0));
      b   = 1'($urandom_range(1, 0));
      cin = 1'($urandom_range(1, 0));
      @(negedge clk);
      tests_run++;
      if ({out_valid, sum, carry, out_last} !== 4'b0000) begin
        failed++;
        $display("FAIL %s idle %0d: got v/s/c/l=%b%b%b%b, expected 0000",
                 name, k, out_valid, sum, carry, out_last);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b1;
    in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({out_valid, sum, carry, out_last, out_valid1, sum1, carry1, out_last1} !== 8'h00) begin
      failed++;
      $display("FAIL reset_outputs: got %b%b%b%b %b%b%b%b, expected 0000 0000",
               out_valid, sum, carry, out_last, out_valid1, sum1, carry1, out_last1);
    end
    in_valid = 1'b0;
    in_valid1 = 1'b0;
    rst_n = 1'b1;
    idle(2, "post_reset");
  endtask

  task automatic test_ff_plus_01();
    logic [7:0] sw;
    logic       co;
    send_word(8'hFF, 8'h01, 1'b0, 8, -1, 0, "ff_plus_01", sw, co);
    tests_run++;
    if (sw !== 8'h00 || co !== 1'b1) begin
      failed++;
      $display("FAIL ff_plus_01 word: got sum=%h carry=%b, expected sum=00 carry=1", sw, co);
    end
    idle(1, "ff_plus_01");
  endtask

  task automatic test_5a_33();
    logic [7:0] sw;
    logic       co;
    send_word(8'h5A, 8'h33, 1'b1, 8, -1, 0, "5a_33", sw, co);
    tests_run++;
    if (sw !== 8'h8E || co !== 1'b0) begin
      failed++;
      $display("FAIL 5a_33 word: got sum=%h carry=%b, expected sum=8e carry=0", sw, co);
    end
    idle(1, "5a_33");
  endtask

  task automatic test_stall();
    logic [7:0] sw;
    logic       co;
    send_word(8'h5A, 8'h33, 1'b1, 8, 4, 3, "stall", sw, co);
    tests_run++;
    if (sw !== 8'h8E || co !== 1'b0) begin
      failed++;
      $display("FAIL stall word: got sum=%h carry=%b, expected sum=8e carry=0", sw, co);
    end
    idle(1, "stall");
  endtask

  task automatic test_back_to_back();
    logic [7:0] sw;
    logic       co;
    send_word(8'h80, 8'h80, 1'b0, 8, -1, 0, "b2b_w1", sw, co);
    tests_run++;
    if (sw !== 8'h00 || co !== 1'b1) begin
      failed++;
      $display("FAIL b2b_w1 word: got sum=%h carry=%b, expected sum=00 carry=1", sw, co);
    end
    send_word(8'h01, 8'h01, 1'b0, 8, -1, 0, "b2b_w2", sw, co);
    tests_run++;
    if (sw !== 8'h02 || co !== 1'b0) begin
      failed++;
      $display("FAIL b2b_w2 word: got sum=%h carry=%b, expected sum=02 carry=0", sw, co);
    end
    idle(1, "b2b");
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] sw;
    logic       co;
    send_word(8'hFF, 8'hFF, 1'b0, 5, -1, 0, "mid_reset_partial", sw, co);
    in_valid = 1'b1; a = 1'b1; b = 1'b1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, sum, carry, out_last} !== 4'b0000) begin
      failed++;
      $display("FAIL async_reset: got v/s/c/l=%b%b%b%b, expected 0000", out_valid, sum, carry, out_last);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if ({out_valid, sum, carry, out_last} !== 4'b0000) begin
      failed++;
      $display("FAIL held_reset: got v/s/c/l=%b%b%b%b, expected 0000", out_valid, sum, carry, out_last);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    idle(1, "after_mid_reset");
    send_word(8'h03, 8'h01, 1'b0, 8, -1, 0, "after_reset_word", sw, co);
    tests_run++;
    if (sw !== 8'h04 || co !== 1'b0) begin
      failed++;
      $display("FAIL after_reset_word: got sum=%h carry=%b, expected sum=04 carry=0", sw, co);
    end
    idle(1, "after_reset_word");
  endtask

  task automatic test_width1();
    exp_t e;
    logic [2:0] beats [2];
    beats[0] = 3'b111;
    beats[1] = 3'b100;
    for (int i = 0; i < 2; i++) begin
      in_valid1 = 1'b1;
      {a1, b1, cin1} = beats[i];
      e.sum   = beats[i][2] ^ beats[i][1] ^ beats[i][0];
      e.carry = (beats[i][2] & beats[i][1]) | (beats[i][2] & beats[i][0]) | (beats[i][1] & beats[i][0]);
      e.last  = 1'b1;
      q.push_back(e);
      @(negedge clk);
      e = q.pop_front();
      tests_run++;
      if (out_valid1 !== 1'b1 || sum1 !== e.sum || carry1 !== e.carry || out_last1 !== e.last) begin
        failed++;
        $display("FAIL width1 beat %0d: got v/s/c/l=%b%b%b%b, expected 1%b%b%b",
                 i, out_valid1, sum1, carry1, out_last1, e.sum, e.carry, e.last);
      end
    end
    in_valid1 = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({out_valid1, sum1, carry1, out_last1} !== 4'b0000) begin
      failed++;
      $display("FAIL width1 idle: got v/s/c/l=%b%b%b%b, expected 0000", out_valid1, sum1, carry1, out_last1);
    end
  endtask

  initial begin
    test_reset();
    test_ff_plus_01();
    test_5a_33();
    test_stall();
    test_back_to_back();
    test_reset_mid_word();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand length in bits; legal range 1..32.
REQ-002 Port: clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port: in_valid, input, 1, current a/b beat valid; one bit per cycle, LSB first.
REQ-005 Port: a, input, 1, operand A bit for this beat.
REQ-006 Port: b, input, 1, operand B bit for this beat.
REQ-007 Port: cin, input, 1, word carry-in; sampled only on the first beat of a word.
REQ-008 Port: out_valid, output, 1, sum/carry valid this cycle.
REQ-009 Port: sum, output, 1, sum bit for the corresponding input beat.
REQ-010 Port: carry, output, 1, carry-out of the corresponding bit position.
REQ-011 Port: out_last, output, 1, marks the output beat of bit WIDTH-1; carry is then the word carry-out.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE (no word in progress, bit count 0) and RUN (word in progress).
REQ-013 IDLE + in_valid: compute with carry_in=cin, bit count -> 1, go to RUN; if WIDTH=1, stay in IDLE.
REQ-014 RUN + in_valid: compute with carry_in = stored carry, increment bit count; on bit WIDTH-1, clear count and go to IDLE.
REQ-015 Any state + in_valid=0: hold state, bit count and stored carry unchanged (stall of any length is legal).
REQ-016 Per accepted beat: sum = a^b^carry_in; carry = majority(a,b,carry_in); the stored carry SHALL take this carry value.
REQ-017 Outputs SHALL be registered: sum, carry, out_valid, out_last appear exactly one cycle after the accepted beat.
REQ-018 out_valid SHALL be high for exactly one cycle per accepted beat and low in every cycle following an in_valid=0 cycle.
REQ-019 out_last SHALL be high only together with out_valid, on the output of bit WIDTH-1.
REQ-020 When out_valid=0, sum, carry, out_last SHALL be 0.
REQ-021 Back-to-back words: the beat after bit WIDTH-1 SHALL start a new word using its own cin; no carry SHALL leak across words.
REQ-022 Bit counter SHALL be ceil(log2(WIDTH+1)) bits wide minimum and never exceed WIDTH-1.
REQ-023 a, b, cin SHALL be ignored when in_valid=0; cin SHALL be ignored on beats other than bit 0.

Reset
REQ-024 rst_n=0 SHALL immediately (asynchronously) force state IDLE, bit count 0, stored carry 0, out_valid=0, sum=0, carry=0, out_last=0.
REQ-025 Reset mid-word SHALL discard the partial word; the first in_valid beat after rst_n rises SHALL be bit 0 of a new word.
REQ-026 in_valid during reset SHALL be ignored; no output beat SHALL result from it.

Verification
REQ-027 WIDTH=8, a=0xFF, b=0x01, cin=0, 8 contiguous beats -> 8 output beats, sum bits 0x00, out_last on 8th with carry=1.
REQ-028 WIDTH=8, a=0x5A, b=0x33, cin=1, contiguous -> sum bits 0x8E LSB-first, final carry=0, outputs 1 cycle after each beat.
REQ-029 Same as REQ-028 with in_valid low 3 cycles after beat 4 -> identical sum bits 0x8E, out_valid low exactly 3 cycles, final carry=0.
REQ-030 Back-to-back: 0x80+0x80 cin=0 then immediately 0x01+0x01 cin=0 -> word1 sum 0x00 carry 1; word2 sum 0x02 carry 0.
REQ-031 rst_n pulsed low after beat 5 of 0xFF+0xFF -> all outputs 0 during reset; next word 0x03+0x01 cin=0 -> sum 0x04, carry 0.
REQ-032 WIDTH=1, beats (a,b,cin)=(1,1,1),(1,0,0) -> (sum,carry)=(1,1),(1,0), out_last=1 on every output beat.
